uart_rx_sampler: RTL

16x-oversampling UART receive front end. Sits directly upstream of the receive FIFO in the UART peripheral: it takes the raw `rx` pin, synchronises and majority-votes it, and deframes start, data, parity and stop bits. Each complete frame is emitted as a 9-bit word with a one-cycle valid pulse plus parity, framing and break flags; the FIFO write side consumes these. Frame parameters use the same encodings the UART register block already drives.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_sample_tick.sv | 45 ++++
 rtl/uart_rx_sampler.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared state type, frame encodings and helpers for the UART receive path.
// Imported by the sample-tick generator and the receive sampler.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } uart_state_e;

    localparam int OVERSAMPLE_DEFAULT = 16;

    localparam logic [1:0] STOP_SIZE_ONE = 2'b01;
    localparam logic [1:0] STOP_SIZE_TWO = 2'b10;

    localparam logic PARITY_ODD  = 1'b1;
    localparam logic PARITY_EVEN = 1'b0;

    localparam logic [3:0] DATA_SIZE_MIN = 4'd6;
    localparam logic [3:0] DATA_SIZE_MAX = 4'd8;

    function automatic logic [3:0] clamp_data_size(input logic [3:0] size);
        logic [3:0] result;
        result = size;
        if (size < DATA_SIZE_MIN) begin
            result = DATA_SIZE_MIN;
        end else if (size > DATA_SIZE_MAX) begin
            result = DATA_SIZE_MAX;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_sample_tick.sv
// Sample-period divider: pulses o_tick every i_div clocks (0 acts as 1) and
// walks the oversample index o_sample through 0..OVERSAMPLE-1.
module uart_sample_tick #(
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int S_WIDTH    = $clog2(OVERSAMPLE)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic [DIV_WIDTH-1:0] i_div,
    output logic                 o_tick,
    output logic [S_WIDTH-1:0]   o_sample
);

    localparam logic [S_WIDTH-1:0] S_LAST = S_WIDTH'(OVERSAMPLE - 1);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic [S_WIDTH-1:0]   r_sample;
    logic [DIV_WIDTH-1:0] w_divLast;
    logic                 w_tick;

    // ">=" keeps the counter from running away if the divisor shrinks mid-count.
    assign w_divLast = (i_div == '0) ? '0 : (i_div - DIV_WIDTH'(1));
    assign w_tick    = (r_cnt >= w_divLast);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_sample <= '0;
        end else if (i_clear) begin
            r_cnt    <= '0;
            r_sample <= '0;
        end else if (w_tick) begin
            r_cnt    <= '0;
            r_sample <= (r_sample == S_LAST) ? '0 : (r_sample + S_WIDTH'(1));
        end else begin
            r_cnt    <= r_cnt + DIV_WIDTH'(1);
        end
    end

    assign o_tick   = w_tick;
    assign o_sample = r_sample;

endmodule

// File: rtl/uart_rx_sampler.sv
// Oversampling UART receive front end: synchronises rx, majority-votes the bit
// centre and deframes start/data/parity/stop into a word plus error flags.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 rx_i,
    input  logic [DIV_WIDTH-1:0] clks_per_sample_i,
    input  logic [3:0]           data_size_i,
    input  logic                 parity_size_i,
    input  logic                 parity_type_i,
    input  logic [1:0]           stop_size_i,
    output logic [8:0]           data_o,
    output logic                 valid_o,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 break_o,
    output logic                 busy_o
);

    localparam int S_WIDTH = $clog2(OVERSAMPLE);
    localparam logic [S_WIDTH-1:0] S_VOTE0 = S_WIDTH'(OVERSAMPLE / 2 - 1);
    localparam logic [S_WIDTH-1:0] S_VOTE1 = S_WIDTH'(OVERSAMPLE / 2);
    localparam logic [S_WIDTH-1:0] S_VOTE2 = S_WIDTH'(OVERSAMPLE / 2 + 1);
    localparam logic [S_WIDTH-1:0] S_LAST  = S_WIDTH'(OVERSAMPLE - 1);

    logic               r_sync1, r_sync2, r_prev;
    uart_state_e        r_state, w_stateNext;
    logic               w_tick;
    logic [S_WIDTH-1:0] w_sample;
    logic               r_samp0, r_samp1;
    logic               w_vote, w_startDet, w_voteTick, w_endTick;
    logic               w_frameDone, w_breakDet, w_parErr;

    logic [3:0]         r_dataSize;
    logic               r_parEn, r_parType, r_twoStop;
    logic [3:0]         r_bitCnt;
    logic [7:0]         r_shift;
    logic               r_parBit, r_anyOne, r_stopErr, r_stopIdx;

    logic [8:0]         r_data;
    logic               r_valid, r_parErr, r_frameErr, r_break, r_busy;

    uart_sample_tick #(
        .OVERSAMPLE (OVERSAMPLE),
        .DIV_WIDTH  (DIV_WIDTH),
        .S_WIDTH    (S_WIDTH)
    ) u_tick (
        .i_clk    (clk_i),
        .i_rst_n  (rst_ni),
        .i_clear  (w_startDet),
        .i_div    (clks_per_sample_i),
        .o_tick   (w_tick),
        .o_sample (w_sample)
    );

    assign w_startDet = en_i && (r_state == IDLE) && !r_sync2 && r_prev;
    assign w_voteTick = w_tick && (w_sample == S_VOTE2);
    assign w_endTick  = w_tick && (w_sample == S_LAST);
    // The third vote sample is the live synchronised line at the deciding tick.
    assign w_vote     = (r_samp0 & r_samp1) | (r_samp0 & r_sync2) | (r_samp1 & r_sync2);
    assign w_parErr   = r_parEn && ((^r_shift ^ r_parBit) != (r_parType == PARITY_ODD));

    always_comb begin
        w_stateNext = r_state;
        w_frameDone = 1'b0;
        w_breakDet  = 1'b0;
        if (!en_i) begin
            w_stateNext = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_startDet) w_stateNext = START;
                end
                START: begin
                    if (w_voteTick && w_vote) w_stateNext = IDLE;
                    else if (w_endTick)       w_stateNext = DATA;
                end
                DATA: begin
                    if (w_endTick && (r_bitCnt == r_dataSize))
                        w_stateNext = r_parEn ? PARITY : STOP;
                end
                PARITY: begin
                    if (w_endTick) w_stateNext = STOP;
                end
                STOP: begin
                    // Finish at the vote rather than bit end so the next start edge is caught.
                    if (w_voteTick) begin
                        if (!r_stopIdx && !r_anyOne && !w_vote) begin
                            w_stateNext = BREAK_WAIT;
                            w_frameDone = 1'b1;
                            w_breakDet  = 1'b1;
                        end else if (r_stopIdx || !r_twoStop) begin
                            w_stateNext = IDLE;
                            w_frameDone = 1'b1;
                        end
                    end
                end
                BREAK_WAIT: begin
                    if (r_sync2) w_stateNext = IDLE;
                end
                default: w_stateNext = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_state <= w_stateNext;
            r_busy  <= (w_stateNext != IDLE);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_samp0    <= 1'b1;
            r_samp1    <= 1'b1;
            r_dataSize <= DATA_SIZE_MAX;
            r_parEn    <= 1'b0;
            r_parType  <= PARITY_EVEN;
            r_twoStop  <= 1'b0;
            r_bitCnt   <= '0;
            r_shift    <= '0;
            r_parBit   <= 1'b0;
            r_anyOne   <= 1'b0;
            r_stopErr  <= 1'b0;
            r_stopIdx  <= 1'b0;
        end else begin
            if (w_tick && (w_sample == S_VOTE0)) r_samp0 <= r_sync2;
            if (w_tick && (w_sample == S_VOTE1)) r_samp1 <= r_sync2;
            if (w_startDet) begin
                r_dataSize <= clamp_data_size(data_size_i);
                r_parEn    <= parity_size_i;
                r_parType  <= parity_type_i;
                r_twoStop  <= (stop_size_i == STOP_SIZE_TWO);
                r_bitCnt   <= '0;
                r_shift    <= '0;
                r_parBit   <= 1'b0;
                r_anyOne   <= 1'b0;
                r_stopErr  <= 1'b0;
                r_stopIdx  <= 1'b0;
            end else begin
                if (w_voteTick && (r_state == DATA) && (r_bitCnt < r_dataSize)) begin
                    r_shift[r_bitCnt[2:0]] <= w_vote;
                    r_bitCnt               <= r_bitCnt + 4'd1;
                    r_anyOne               <= r_anyOne | w_vote;
                end
                if (w_voteTick && (r_state == PARITY)) begin
                    r_parBit <= w_vote;
                    r_anyOne <= r_anyOne | w_vote;
                end
                if (w_voteTick && (r_state == STOP) && !w_vote) r_stopErr <= 1'b1;
                if (w_endTick && (r_state == STOP)) r_stopIdx <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_parErr   <= 1'b0;
            r_frameErr <= 1'b0;
            r_break    <= 1'b0;
        end else begin
            r_valid <= w_frameDone;
            if (w_frameDone) begin
                r_data     <= {r_parBit, r_shift};
                r_parErr   <= w_parErr;
                r_frameErr <= r_stopErr | !w_vote;
                r_break    <= w_breakDet;
            end
        end
    end

    assign data_o       = r_data;
    assign valid_o      = r_valid;
    assign parity_err_o = r_parErr;
    assign frame_err_o  = r_frameErr;
    assign break_o      = r_break;
    assign busy_o       = r_busy;

endmodule
